// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU EX-stage port and a debug/loader port.
// CPU has priority, bounded by a starvation limit; the debug port can lock the bus for bursts.
module dmem_arbiter #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_MW,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  localparam int unsigned SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_nxt;
  logic          w_cpu_gnt;
  logic          w_dbg_gnt;
  logic          w_cpu_rd;
  logic          w_dbg_rd;

  logic          r_cpu_rvalid;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_dbg_rvalid;
  logic [DW-1:0] r_dbg_rdata;

  // State and starvation counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_ARB;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Grant decision, next state and streak update; no grants while reset is held
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_dbg_gnt    = 1'b0;
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;

    if (rst) begin
      case (r_state)
        ST_ARB: begin
          if (cpu_req && dbg_req) begin
            if (r_streak == STREAK_MAX) w_dbg_gnt = 1'b1;
            else                        w_cpu_gnt = 1'b1;
          end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            w_dbg_gnt = 1'b1;
          end
        end
        ST_LOCK: w_dbg_gnt = dbg_req;
        default: ;
      endcase
    end

    case (r_state)
      ST_ARB:  if (w_dbg_gnt && dbg_lock) w_state_nxt = ST_LOCK;
      ST_LOCK: if (!dbg_lock)             w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase

    if (w_dbg_gnt || !dbg_req) begin
      w_streak_nxt = '0;
    end else if (w_cpu_gnt && (r_streak != STREAK_MAX)) begin
      w_streak_nxt = r_streak + SW'(1);
    end
  end

  assign w_cpu_rd = w_cpu_gnt & ~cpu_we;
  assign w_dbg_rd = w_dbg_gnt & ~dbg_we;

  // Read data capture; rdata holds between reads of the same port
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd;
      r_dbg_rvalid <= w_dbg_rd;
      if (w_cpu_rd) r_cpu_rdata <= mem_dataout;
      if (w_dbg_rd) r_dbg_rdata <= mem_dataout;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

  // Owner drives the memory; an idle bus is parked at zero
  assign mem_MW     = (w_cpu_gnt & cpu_we) | (w_dbg_gnt & dbg_we);
  assign mem_addr   = w_cpu_gnt ? cpu_addr  : (w_dbg_gnt ? dbg_addr  : '0);
  assign mem_datain = w_cpu_gnt ? cpu_wdata : (w_dbg_gnt ? dbg_wdata : '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/bus checks plus a read-data scoreboard
// fed by the stimulus and drained by an independent monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [5:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_MW;
  logic [5:0]  mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  logic [31:0] mem [64];
  logic        mem_clr = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_MW(mem_MW), .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  // Single-port memory model: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_MW) begin
      mem[mem_addr] <= mem_datain;
    end
  end
  assign mem_dataout = mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check grants/bus, queue the expected read data
  task automatic cyc(input logic rstn, input logic creq, input logic cwe,
                     input logic [5:0] caddr, input logic [31:0] cwd,
                     input logic dreq, input logic dwe, input logic dlock,
                     input logic [5:0] daddr, input logic [31:0] dwd,
                     input logic ecg, input logic edg, input logic [31:0] erd,
                     input string nm);
    logic [5:0]  eaddr;
    logic [31:0] edat;
    @(negedge clk);
    rst = rstn;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = daddr; dbg_wdata = dwd;
    eaddr = ecg ? caddr : (edg ? daddr : 6'd0);
    edat  = ecg ? cwd   : (edg ? dwd   : 32'd0);
    if (ecg && !cwe) cpu_q.push_back(erd);
    if (edg && !dwe) dbg_q.push_back(erd);
    #1;
    chk({nm, ".cpu_gnt"},   32'(cpu_gnt),   32'(ecg));
    chk({nm, ".dbg_gnt"},   32'(dbg_gnt),   32'(edg));
    chk({nm, ".cpu_stall"}, 32'(cpu_stall), 32'(creq & ~ecg));
    chk({nm, ".mem_MW"},    32'(mem_MW),    32'((ecg & cwe) | (edg & dwe)));
    chk({nm, ".mem_addr"},  32'(mem_addr),  32'(eaddr));
    chk({nm, ".mem_datain"}, mem_datain,    edat);
  endtask

  task automatic idle(input string nm);
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 32'd0, nm);
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [31:0] d, input string nm);
    cyc(1'b1, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 32'd0, nm);
  endtask

  task automatic cpu_rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    cyc(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, e, nm);
  endtask

  // Scoreboard monitor: every read grant must produce exactly one rvalid on the next edge
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_rvalid || dbg_rvalid)
        chk("rvalid_exclusive", 32'(cpu_rvalid & dbg_rvalid), 32'd0);
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        if (cpu_rvalid) chk("cpu_rdata", cpu_rdata, e);
      end else if (cpu_rvalid) begin
        chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
      end
      if (dbg_q.size() != 0) begin
        e = dbg_q.pop_front();
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        if (dbg_rvalid) chk("dbg_rdata", dbg_rdata, e);
      end else if (dbg_rvalid) begin
        chk("dbg_rvalid_unexpected", 32'(dbg_rvalid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: requests present but nothing is granted or driven
    cyc(1'b0, 1'b1, 1'b1, 6'd3, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 6'd4, 32'h8765_4321,
        1'b0, 1'b0, 32'd0, "reset");
    mem_clr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0,
        1'b0, 1'b0, 32'd0, "reset2");
    chk("reset.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("reset.dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("reset.cpu_rdata", cpu_rdata, 32'd0);
    chk("reset.dbg_rdata", dbg_rdata, 32'd0);

    // 1: CPU write then read back
    cpu_wr(6'd5, 32'hDEAD_BEEF, "t1.wr");
    cpu_rd(6'd5, 32'hDEAD_BEEF, "t1.rd");
    idle("t1.idle");

    // 2: contention, CPU x4 then DBG
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 1'b0, 6'd5, 32'd0,
          (i % 5) != 4, (i % 5) == 4, 32'hDEAD_BEEF, "t2.contend");
    end
    idle("t2.idle");

    // 3: debug waits out the CPU streak, then a locked burst of 3 writes
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b1, 1'b1, 6'd0, 32'h1111_0000,
          1'b1, 1'b0, 32'hDEAD_BEEF, "t3.cpu_first");
    end
    cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b1, 1'b1, 6'd0, 32'h1111_0000,
        1'b0, 1'b1, 32'd0, "t3.burst0");
    cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b1, 1'b1, 6'd1, 32'h2222_0001,
        1'b0, 1'b1, 32'd0, "t3.burst1");
    cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b1, 1'b0, 6'd2, 32'h3333_0002,
        1'b0, 1'b1, 32'd0, "t3.burst2");
    cpu_rd(6'd0, 32'h1111_0000, "t3.rd0");
    cpu_rd(6'd1, 32'h2222_0001, "t3.rd1");
    cpu_rd(6'd2, 32'h3333_0002, "t3.rd2");
    idle("t3.idle");

    // 4: debug read while CPU is stalled by the lock
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 1'b1, 6'd7, 32'h7777_0007,
        1'b0, 1'b1, 32'd0, "t4.dwr");
    cyc(1'b1, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 1'b0, 6'd7, 32'd0,
        1'b0, 1'b1, 32'h7777_0007, "t4.drd");
    cpu_rd(6'd5, 32'hDEAD_BEEF, "t4.cpu");
    chk("t4.cpu_rvalid_quiet", 32'(cpu_rvalid), 32'd0);
    idle("t4.idle");

    // 5: reset lands in LOCK; the write attempted under reset must not happen
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1, 6'd7, 32'd0,
        1'b0, 1'b1, 32'h7777_0007, "t5.lock_rd");
    cyc(1'b0, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b1, 1'b1, 6'd7, 32'h0BAD_0BAD,
        1'b0, 1'b0, 32'd0, "t5.in_reset");
    cpu_rd(6'd5, 32'hDEAD_BEEF, "t5.after");
    chk("t5.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("t5.dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    idle("t5.idle");

    // 6: address extremes are independent
    cpu_wr(6'd63, 32'hA5A5_003F, "t6.wr63");
    cpu_wr(6'd0,  32'h5A5A_0000, "t6.wr0");
    cpu_rd(6'd63, 32'hA5A5_003F, "t6.rd63");
    cpu_rd(6'd0,  32'h5A5A_0000, "t6.rd0");
    cpu_rd(6'd1,  32'h2222_0001, "t6.rd1");
    cpu_rd(6'd62, 32'h0000_0000, "t6.rd62");
    cpu_rd(6'd7,  32'h7777_0007, "t6.rd7");
    idle("end.idle0");
    idle("end.idle1");

    chk("end.cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("end.dbg_q_empty", 32'(dbg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
